// File: rtl/fc_result_writer.sv
// Purpose : FC-layer result write-back; quantises PO accumulator lanes per beat and
//           writes one packed word per beat to the output-neuron RAM at an auto-incrementing address.
// Latency : a beat accepted at cycle N is written (fc_outneuron_wren_a=1) at cycle N+2.
// Backpr. : in_ready is high only in RUN and is low while layer_start is asserted; no stall downstream.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   layer_start          one-cycle pulse that arms (or aborts and re-arms) a layer
//   in_valid/in_ready    result beat handshake; result lane i at [i*ACCUM+:ACCUM]
//   fc_outneuron_wren_a  RAM write enable, with address and dataout (lane i at [i*DATA+:DATA])
//   layer_done           pulses with the write at address OUTNEURON/PO-1
//   busy                 high while in RUN or DRAIN
//
// Optional feature macro: FC_RESULT_RELU_EN (negative quantised lanes are written as 0).
module fc_result_writer #(
   parameter int DATA_WIDTH_FC           = 16,
   parameter int ACCUM_DATA_WIDTH_FC     = 32,
   parameter int FRAC_SHIFT              = 12,
   parameter int PO                      = 2,
   parameter int OUTNEURON               = 64,
   parameter int FC_OUTNEURON_ADDR_WIDTH = 5
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  layer_start,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [PO*ACCUM_DATA_WIDTH_FC-1:0]     result,
   output logic                                  fc_outneuron_wren_a,
   output logic [FC_OUTNEURON_ADDR_WIDTH-1:0]    address,
   output logic [PO*DATA_WIDTH_FC-1:0]           dataout,
   output logic                                  layer_done,
   output logic                                  busy
);

   localparam int DW     = DATA_WIDTH_FC;
   localparam int AW     = ACCUM_DATA_WIDTH_FC;
   localparam int ADW    = FC_OUTNEURON_ADDR_WIDTH;
   localparam int NBEATS = OUTNEURON / PO;
   localparam int CNT_W  = $clog2(NBEATS + 1);

   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NBEATS - 1);
   localparam logic [ADW-1:0]   LAST_ADDR = ADW'(NBEATS - 1);

   // Half-LSB rounding bias; zero when no shift is applied.
   localparam logic signed [AW:0] RND =
      (FRAC_SHIFT > 0) ? ((AW+1)'(1) << ((FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0)) : '0;
   localparam logic signed [AW:0] SAT_MAX = $signed({{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}});
   localparam logic signed [AW:0] SAT_MIN = $signed({{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}});

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic                 s1_vld_q;
   logic [PO*DW-1:0]     s1_dat_q;
   logic                 wren_q;
   logic                 done_q;
   logic [AW-1:0]        unused_hi;
   logic [ADW-1:0]       addr_q;
   logic [ADW-1:0]       wr_ptr_q;
   logic [PO*DW-1:0]     dout_q;
   logic [PO*DW-1:0]     q_lanes;
   logic                 accept;
   logic                 last_beat;

   // Round (add half LSB at AW+1 bits so it never overflows), arithmetic shift, saturate.
   function automatic logic [DW-1:0] quantise(input logic [AW-1:0] r);
      logic signed [AW:0] t;
      logic signed [AW:0] q;
      logic [DW-1:0]      s;
      t = $signed({r[AW-1], r}) + RND;
      q = t >>> FRAC_SHIFT;
      if (q > SAT_MAX) begin
         s = SAT_MAX[DW-1:0];
      end else if (q < SAT_MIN) begin
         s = SAT_MIN[DW-1:0];
      end else begin
         s = q[DW-1:0];
      end
`ifdef FC_RESULT_RELU_EN
      if (s[DW-1]) begin
         s = '0;
      end
`endif
      return s;
   endfunction

   for (genvar i = 0; i < PO; i++) begin : g_lane
      assign q_lanes[i*DW +: DW] = quantise(result[i*AW +: AW]);
   end

   assign unused_hi = '0;

   // A start in the same cycle as a valid beat wins: the beat is refused.
   assign in_ready  = (state_q == RUN) && !layer_start;
   assign accept    = in_ready && in_valid;
   assign last_beat = accept && (beat_cnt_q == LAST_CNT);

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      if (layer_start) begin
         beat_cnt_d = '0;
      end else if (accept) begin
         beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
      case (state_q)
         IDLE: begin
            if (layer_start) state_d = RUN;
         end
         RUN: begin
            if (layer_start)    state_d = RUN;
            else if (last_beat) state_d = DRAIN;
         end
         DRAIN: begin
            // done_q marks the final write issuing this cycle.
            if (layer_start) state_d = RUN;
            else if (done_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         s1_vld_q   <= 1'b0;
         s1_dat_q   <= '0;
         wren_q     <= 1'b0;
         done_q     <= 1'b0;
         addr_q     <= '0;
         wr_ptr_q   <= '0;
         dout_q     <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         if (layer_start) begin
            // Abort: discard in-flight beats, keep dataout as last written.
            s1_vld_q <= 1'b0;
            wren_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            wr_ptr_q <= '0;
         end else begin
            s1_vld_q <= accept;
            if (accept) begin
               s1_dat_q <= q_lanes;
            end
            wren_q <= s1_vld_q;
            done_q <= s1_vld_q && (wr_ptr_q == LAST_ADDR);
            if (s1_vld_q) begin
               dout_q   <= s1_dat_q;
               addr_q   <= wr_ptr_q;
               wr_ptr_q <= (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADW'(1);
            end
         end
      end
   end

   assign fc_outneuron_wren_a = wren_q;
   assign address             = addr_q;
   assign dataout             = dout_q;
   assign layer_done          = done_q;
   assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_fc_result_writer.sv
module tb_fc_result_writer;

   localparam int DW  = 16;
   localparam int AW  = 32;
   localparam int FS  = 12;
   localparam int PO  = 2;
   localparam int ON  = 64;
   localparam int ADW = 5;
   localparam int NB  = ON / PO;

`ifdef FC_RESULT_RELU_EN
   localparam logic [31:0] EXP_B1 = 32'h0000_0002;
   localparam logic [31:0] EXP_B2 = 32'h0000_7FFF;
`else
   localparam logic [31:0] EXP_B1 = 32'hFFFF_0002;
   localparam logic [31:0] EXP_B2 = 32'h8000_7FFF;
`endif
   localparam logic [31:0] EXP_B3 = 32'h0001_0000;
   localparam logic [31:0] EXP_B4 = 32'h0000_0001;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               layer_start = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [PO*AW-1:0]   result = '0;
   logic               fc_outneuron_wren_a;
   logic [ADW-1:0]     address;
   logic [PO*DW-1:0]   dataout;
   logic               layer_done;
   logic               busy;

   always #5 clock = ~clock;

   fc_result_writer #(
      .DATA_WIDTH_FC(DW), .ACCUM_DATA_WIDTH_FC(AW), .FRAC_SHIFT(FS),
      .PO(PO), .OUTNEURON(ON), .FC_OUTNEURON_ADDR_WIDTH(ADW)
   ) dut (
      .clock(clock), .reset(reset), .layer_start(layer_start),
      .in_valid(in_valid), .in_ready(in_ready), .result(result),
      .fc_outneuron_wren_a(fc_outneuron_wren_a), .address(address),
      .dataout(dataout), .layer_done(layer_done), .busy(busy)
   );

   typedef struct {
      int               cyc;
      int               addr;
      logic [PO*DW-1:0] data;
      bit               done;
   } wr_t;

   int               n_pass = 0;
   int               n_total = 0;
   int               cyc = 0;
   wr_t              expq[$];
   bit               mrun = 0;
   int               mcount = 0;
   int               hold_addr = 0;
   logic [PO*DW-1:0] hold_data = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference quantiser: round half up, floor-divide by 2^FS, clamp, optional ReLU.
   function automatic logic [DW-1:0] ref_lane(input logic [AW-1:0] r);
      longint v, t, q, dv;
      logic [63:0] qb;
      dv = longint'(1) << FS;
      v  = longint'($signed(r));
      t  = v + dv / 2;
      if (t >= 0) q = t / dv;
      else        q = -((-t + dv - 1) / dv);
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
`ifdef FC_RESULT_RELU_EN
      if (q < 0) q = 0;
`endif
      qb = q;
      return qb[DW-1:0];
   endfunction

   function automatic logic [PO*DW-1:0] ref_beat(input logic [PO*AW-1:0] d);
      logic [PO*DW-1:0] o;
      o = '0;
      for (int i = 0; i < PO; i++) o[i*DW +: DW] = ref_lane(d[i*AW +: AW]);
      return o;
   endfunction

   function automatic logic [AW-1:0] rand_lane();
      int m;
      logic [AW-1:0] w;
      m = $urandom_range(0, 3);
      case (m)
         0:       w = $urandom;
         1:       w = AW'($urandom_range(0, 16384)) - AW'(8192);
         2:       w = $urandom_range(0, 1) ? 32'h7FF0_0000 + $urandom_range(0, 255)
                                           : 32'h8000_0000 + $urandom_range(0, 255);
         default: w = (AW'($urandom_range(0, 64)) << FS) - AW'(32 << FS) + AW'(2048)
                      - AW'($urandom_range(0, 1));
      endcase
      return w;
   endfunction

   function automatic logic [PO*AW-1:0] rand_beat();
      logic [PO*AW-1:0] d;
      for (int i = 0; i < PO; i++) d[i*AW +: AW] = rand_lane();
      return d;
   endfunction

   // Compare every output of the current cycle against the model's expectation.
   task automatic monitor_check();
      bit  exp_busy;
      wr_t w;
      exp_busy = mrun || (expq.size() > 0);
      check("busy", 64'(busy), 64'(exp_busy));
      check("in_ready", 64'(in_ready), 64'(mrun && !layer_start));
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
         w = expq.pop_front();
         check("wren", 64'(fc_outneuron_wren_a), 64'd1);
         check("address", 64'(address), 64'(w.addr));
         check("dataout", 64'(dataout), 64'(w.data));
         check("layer_done", 64'(layer_done), 64'(w.done));
         hold_addr = w.addr;
         hold_data = w.data;
      end else begin
         check("wren_idle", 64'(fc_outneuron_wren_a), 64'd0);
         check("address_hold", 64'(address), 64'(hold_addr));
         check("dataout_hold", 64'(dataout), 64'(hold_data));
         check("layer_done_idle", 64'(layer_done), 64'd0);
      end
   endtask

   // k-th accepted beat of a layer lands at address k two cycles later.
   task automatic model_update(input bit st, input bit v, input logic [PO*AW-1:0] d);
      wr_t w;
      if (st) begin
         mrun = 1;
         mcount = 0;
         hold_addr = 0;
         expq.delete();
      end else if (v && mrun) begin
         w.cyc  = cyc + 2;
         w.addr = mcount;
         w.data = ref_beat(d);
         w.done = (mcount == NB - 1);
         expq.push_back(w);
         mcount++;
         if (mcount == NB) mrun = 0;
      end
   endtask

   // One clock cycle: drive, check at negedge, update model at the edge.
   task automatic step(input bit st, input bit v, input logic [PO*AW-1:0] d);
      layer_start = st;
      in_valid    = v;
      result      = d;
      @(negedge clock);
      monitor_check();
      @(posedge clock);
      model_update(st, v, d);
      cyc++;
      #1;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((mrun || expq.size() > 0) && g < 20) begin
         step(0, 0, '0);
         g++;
      end
      step(0, 0, '0);
      step(0, 0, '0);
   endtask

   initial begin
      int n;
      bit v;

      repeat (3) @(posedge clock);
      #1;
      check("rst_wren", 64'(fc_outneuron_wren_a), 64'd0);
      check("rst_address", 64'(address), 64'd0);
      check("rst_dataout", 64'(dataout), 64'd0);
      check("rst_layer_done", 64'(layer_done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      reset = 1'b0;

      // Valid in IDLE is ignored.
      step(0, 1, rand_beat());
      step(0, 0, '0);

      // Directed quantisation points, each beat followed by a bubble.
      step(1, 0, '0);
      step(0, 1, {32'hFFFF_F000, 32'h0000_1800});
      step(0, 0, '0);
      check("b1_wren", 64'(fc_outneuron_wren_a), 64'd1);
      check("b1_addr", 64'(address), 64'd0);
      check("b1_data", 64'(dataout), 64'(EXP_B1));
      step(0, 1, {32'hF000_0000, 32'h0800_0000});
      step(0, 0, '0);
      check("b2_addr", 64'(address), 64'd1);
      check("b2_data", 64'(dataout), 64'(EXP_B2));
      step(0, 1, {32'h0000_0800, 32'h0000_07FF});
      step(0, 0, '0);
      check("b3_addr", 64'(address), 64'd2);
      check("b3_data", 64'(dataout), 64'(EXP_B3));
      step(0, 1, {32'hFFFF_F800, 32'h0000_0800});
      step(0, 0, '0);
      check("b4_addr", 64'(address), 64'd3);
      check("b4_data", 64'(dataout), 64'(EXP_B4));

      // Restart with a coincident valid beat (refused), then a full back-to-back layer.
      step(1, 1, rand_beat());
      for (int i = 0; i < NB; i++) step(0, 1, rand_beat());
      drain();

      // Next layer with bubbles: 1,0,1 then random gaps.
      step(1, 0, '0);
      n = 0;
      for (int k = 0; k < 200 && n < NB; k++) begin
         v = (k < 3) ? (k != 1) : ($urandom_range(0, 2) != 0);
         step(0, v, rand_beat());
         if (v) n++;
      end
      drain();

      // Abort after 5 accepted beats, then a full layer from address 0.
      step(1, 0, '0);
      for (int i = 0; i < 5; i++) step(0, 1, rand_beat());
      step(1, 1, rand_beat());
      n = 0;
      for (int k = 0; k < 200 && n < NB; k++) begin
         v = ($urandom_range(0, 4) != 0);
         step(0, v, rand_beat());
         if (v) n++;
      end
      drain();

      // Asynchronous reset mid-layer.
      step(1, 0, '0);
      for (int i = 0; i < 3; i++) step(0, 1, rand_beat());
      in_valid = 1'b1;
      result   = rand_beat();
      #2;
      reset = 1'b1;
      #1;
      check("arst_wren", 64'(fc_outneuron_wren_a), 64'd0);
      check("arst_address", 64'(address), 64'd0);
      check("arst_dataout", 64'(dataout), 64'd0);
      check("arst_layer_done", 64'(layer_done), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd0);
      mrun = 0;
      mcount = 0;
      hold_addr = 0;
      hold_data = '0;
      expq.delete();
      @(posedge clock);
      cyc++;
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      step(0, 0, '0);
      step(1, 0, '0);
      step(0, 1, rand_beat());
      step(0, 1, rand_beat());
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fc_result_writer.md
Name: fc_result_writer

Overview:
Parametrised successor to the FC-layer result write-back stage. Accepts PO parallel accumulator results per beat through a valid/ready handshake. Rounds, shifts and saturates each lane to DATA_WIDTH_FC, then writes one packed word per beat into the output-neuron RAM at an auto-incrementing address. Sits between the FC MAC array and the fc_outneuron memory, and signals layer completion to the FC controller.

Parameters:
DATA_WIDTH_FC, 16, output neuron width (signed, two's complement)
ACCUM_DATA_WIDTH_FC, 32, accumulator lane width (signed)
FRAC_SHIFT, 12, arithmetic right shift applied before saturation; 0 = no shift, no rounding
PO, 2, parallel output lanes per beat
OUTNEURON, 64, output neurons per layer; must be a multiple of PO
FC_OUTNEURON_ADDR_WIDTH, 5, write address width; must be >= clog2(OUTNEURON/PO)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
layer_start  in  1  one-cycle pulse; arms a new layer
in_valid  in  1  result beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
result  in  PO*ACCUM_DATA_WIDTH_FC  lane i at bits [i*ACCUM+:ACCUM]
fc_outneuron_wren_a  out  1  RAM write enable
address  out  FC_OUTNEURON_ADDR_WIDTH  RAM write address
dataout  out  PO*DATA_WIDTH_FC  packed quantised lanes, lane i at [i*DATA+:DATA]
layer_done  out  1  one-cycle pulse coincident with the last write of a layer
busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; in_ready, fc_outneuron_wren_a, layer_done and busy = 0; address = 0; dataout = 0; beat counter = 0; pipeline valid bits = 0.
- FSM states:
  - IDLE: in_ready=0. layer_start -> RUN; beat counter and address cleared.
  - RUN: in_ready=1. Each accepted beat increments the beat counter. When the beat reaching OUTNEURON/PO is accepted -> DRAIN, and in_ready drops on the next cycle.
  - DRAIN: in_ready=0. Waits until the final write has issued -> IDLE.
- Pipeline, 2 stages:
  - Stage 1 registers the quantised lanes on acceptance.
  - Stage 2 drives fc_outneuron_wren_a=1 with dataout and address.
  - Latency: accept at cycle N -> wren high at cycle N+2.
  - Back-to-back beats give back-to-back writes. Bubbles in in_valid give bubbles in wren.
- Quantise, per lane:
  - t = result + 2^(FRAC_SHIFT-1) when FRAC_SHIFT>0; computed at ACCUM+1 bits, no overflow.
  - q = t >>> FRAC_SHIFT (arithmetic shift).
  - Saturate q to [-2^(DATA-1), 2^(DATA-1)-1].
- Address:
  - Starts at 0 for each layer and increments after every write.
  - After writing OUTNEURON/PO-1 it wraps to 0.
  - address holds its value while wren=0.
- layer_done: high exactly in the cycle of the write at address OUTNEURON/PO-1.
- dataout holds its last value when no write is in progress.
- layer_start while in RUN or DRAIN: aborts the current layer.
  - In-flight stage-1/2 data is discarded; its wren is suppressed.
  - address and counter clear to 0; state stays or returns to RUN.
  - No layer_done is issued for the aborted layer.
- layer_start and in_valid in the same cycle: start wins, and the beat is not accepted.
- in_valid while in IDLE or DRAIN: ignored, because in_ready=0.
- Reset asserted mid-layer: everything returns to reset values immediately; no partial write completes.

Optional Feature:
FC_RESULT_RELU_EN
- Defined: after saturation, any negative lane is forced to 0. Lanes that are zero or positive pass unchanged. Latency is unchanged.
- Undefined: signed saturated values are written as is. No extra logic is present.

Test Plan:
Reset then single beat: OUTNEURON=4, PO=2, layer_start, then one beat of lanes {0x00001800, 0xFFFFF000} -> 2 cycles later wren=1, address=0, dataout lane0=0x0002, lane1=0xFFFF (0x0000 with FC_RESULT_RELU_EN).
Saturation: lanes {0x08000000, 0xF0000000} -> lane0=0x7FFF, lane1=0x8000.
Rounding boundary: lane 0x000007FF -> 0x0000; lane 0x00000800 -> 0x0001; lane 0xFFFFF800 -> 0x0000.
Full layer, back-to-back: OUTNEURON=64, PO=2, 32 consecutive beats -> 32 consecutive writes at addresses 0..31; layer_done pulses with address 31; in_ready=0 afterwards; busy falls one cycle after the last write; the next layer starts again at address 0.
Gapped input: in_valid toggling 1,0,1 -> wren shows matching bubbles and address increments only on writes.
Abort: layer_start after 5 accepted beats -> no further wren for in-flight beats; address=0; no layer_done; the new layer writes from 0. Reset asserted mid-layer -> all outputs are 0 within the same cycle.
